// File: rtl/sumlatch_uart_multi_pkg.sv
// sumlatch_uart_multi_pkg: shared UART constants, serialiser state encoding and byte-count helper
package sumlatch_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
  function automatic int calc_nbytes(input int sum_w);
    return (sum_w + UART_DATA_BITS - 1) / UART_DATA_BITS;
  endfunction
endpackage

// File: rtl/sumlatch_uart_multi_if.sv
// sumlatch_uart_multi_if: operand/strobe inputs and UART/sum outputs of the sum-latch core; master drives strobes, slave is the core
interface sumlatch_uart_multi_if #(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 2
);
  localparam int SUM_W = DATA_W + $clog2(NUM_CH);
  logic [NUM_CH-1:0] save_n;
  logic [DATA_W-1:0] data_input;
  logic              uart_tx_en;
  logic              uart_txd;
  logic              uart_tx_busy;
  logic [SUM_W-1:0]  sum_out;
  modport master (
    output save_n, data_input, uart_tx_en,
    input  uart_txd, uart_tx_busy, sum_out
  );
  modport slave (
    input  save_n, data_input, uart_tx_en,
    output uart_txd, uart_tx_busy, sum_out
  );
endinterface

// File: rtl/sumlatch_uart_multi_tx_byte.sv
// uart_tx_byte: single-byte UART serialiser (start/done handshake, 8N1 or 8E1 with SUMLATCH_PARITY_EN); ports clk, reset, i_start, i_data, o_txd, o_busy, o_done
module uart_tx_byte
  import sumlatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_START = 3'(START);
  localparam logic [2:0] S_DATA  = 3'(DATA);
  localparam logic [2:0] S_STOP  = 3'(STOP);
`ifdef SUMLATCH_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(PARITY);
  logic r_par;
`endif
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_sh;
  logic             r_txd;
  logic             r_busy;
  logic             w_tick;
  assign w_tick = r_cnt == CNT_W'(CLKS_PER_BIT - 1);
  assign o_done = (r_state == S_STOP) && w_tick;
  assign o_txd  = r_txd;
  assign o_busy = r_busy;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_START;
          r_sh    <= i_data;
          r_txd   <= 1'b0;
          r_busy  <= 1'b1;
        end
        S_START: if (w_tick) begin
          r_state <= S_DATA;
          r_bit   <= '0;
          r_txd   <= r_sh[0];
        end
        S_DATA: if (w_tick) begin
          r_sh  <= r_sh >> 1;
          r_bit <= r_bit + 1'b1;
          if (r_bit == 3'd7) begin
`ifdef SUMLATCH_PARITY_EN
            r_state <= S_PARITY;
            r_txd   <= r_par;
`else
            r_state <= S_STOP;
            r_txd   <= 1'b1;
`endif
          end else
            r_txd <= r_sh[1];
        end
`ifdef SUMLATCH_PARITY_EN
        S_PARITY: if (w_tick) begin
          r_state <= S_STOP;
          r_txd   <= 1'b1;
        end
`endif
        S_STOP: if (w_tick) begin
          if (i_start) begin
            r_state <= S_START;
            r_sh    <= i_data;
            r_txd   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef SUMLATCH_PARITY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) r_par <= 1'b0;
    else if (i_start && (r_state == S_IDLE || o_done)) r_par <= ^i_data;
`endif
endmodule

// File: rtl/sumlatch_uart_multi.sv
// sumlatch_uart_multi: latches NUM_CH operands under save strobes, registers their sum and sends it LSB byte first over UART (8E1 when SUMLATCH_PARITY_EN); ports clk, reset, bus (save_n, data_input, uart_tx_en, uart_txd, uart_tx_busy, sum_out)
module sumlatch_uart_multi
  import sumlatch_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int NUM_CH       = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  sumlatch_uart_multi_if.slave        bus
);
  localparam int SUM_W  = DATA_W + $clog2(NUM_CH);
  localparam int NBYTES = calc_nbytes(SUM_W);
  localparam int SNAP_W = (NBYTES + 1) * UART_DATA_BITS;
  localparam int IDX_W  = NBYTES > 1 ? $clog2(NBYTES) : 1;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_save_sync;
  logic [NUM_CH-1:0]                  r_save_prev;
  logic [NUM_CH-1:0]                  w_save_fall;
  logic [SYNC_STAGES-1:0]             r_en_sync;
  logic                               r_en_prev;
  logic                               w_en_rise;
  logic [DATA_W-1:0]                  r_op [NUM_CH];
  logic [SUM_W-1:0]                   w_sum;
  logic [SUM_W-1:0]                   r_sum;
  logic [SNAP_W-1:0]                  r_snap;
  logic [SNAP_W-1:0]                  w_pad;
  logic [IDX_W-1:0]                   r_byte_idx;
  logic                               w_txd;
  logic                               w_busy;
  logic                               w_done;
  logic                               w_first;
  logic                               w_next;
  logic [7:0]                         w_byte;
  assign w_save_fall = r_save_prev & ~r_save_sync[SYNC_STAGES-1];
  assign w_en_rise   = r_en_sync[SYNC_STAGES-1] & ~r_en_prev;
  assign w_pad       = SNAP_W'(r_sum);
  assign w_first     = w_en_rise & ~w_busy;
  assign w_next      = w_done && (r_byte_idx != IDX_W'(NBYTES - 1));
  // r_snap[7:0] is the byte on the wire, so the next byte always sits at [15:8]
  assign w_byte      = w_first ? w_pad[7:0] : r_snap[15:8];
  assign bus.uart_txd     = w_txd;
  assign bus.uart_tx_busy = w_busy;
  assign bus.sum_out      = r_sum;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_save_sync <= '1;
      r_save_prev <= '1;
      r_en_sync   <= '0;
      r_en_prev   <= 1'b0;
    end else begin
      r_save_sync <= {r_save_sync[SYNC_STAGES-2:0], bus.save_n};
      r_save_prev <= r_save_sync[SYNC_STAGES-1];
      r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], bus.uart_tx_en};
      r_en_prev   <= r_en_sync[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_op[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) if (w_save_fall[i]) r_op[i] <= bus.data_input;
    end
  end
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) w_sum = w_sum + SUM_W'(r_op[i]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sum <= '0;
    else r_sum <= w_sum;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap     <= '0;
      r_byte_idx <= '0;
    end else if (w_first) begin
      r_snap     <= w_pad;
      r_byte_idx <= '0;
    end else if (w_next) begin
      r_snap     <= r_snap >> UART_DATA_BITS;
      r_byte_idx <= r_byte_idx + 1'b1;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_first | w_next),
    .i_data  (w_byte),
    .o_txd   (w_txd),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );
endmodule

// File: tb/tb_sumlatch_uart_multi.sv
// tb_sumlatch_uart_multi: self-checking bench for sumlatch_uart_multi (two configurations, table vectors, random saves, frame decoding)
module tb_sumlatch_uart_multi;
  localparam int CPB = 4;
`ifdef SUMLATCH_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  sumlatch_uart_multi_if #(.DATA_W(4), .NUM_CH(2)) ia ();
  sumlatch_uart_multi_if #(.DATA_W(8), .NUM_CH(4)) ib ();
  sumlatch_uart_multi #(.DATA_W(4), .NUM_CH(2), .CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ia));
  sumlatch_uart_multi #(.DATA_W(8), .NUM_CH(4), .CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ib));
  typedef struct {
    logic [1:0] mask;
    logic [3:0] data;
    int         exp;
  } vec_t;
  vec_t tv [7];
  int n_pass = 0;
  int n_total = 0;
  int ma [2];
  int mb [4];
  task automatic chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
  function automatic int sum_a();
    return ma[0] + ma[1];
  endfunction
  function automatic int sum_b();
    return mb[0] + mb[1] + mb[2] + mb[3];
  endfunction
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef SUMLATCH_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction
  function automatic logic get_busy(input int sel);
    return sel == 0 ? ia.uart_tx_busy : ib.uart_tx_busy;
  endfunction
  function automatic logic get_txd(input int sel);
    return sel == 0 ? ia.uart_txd : ib.uart_txd;
  endfunction
  task automatic set_en(input int sel, input logic v);
    if (sel == 0) ia.uart_tx_en = v;
    else ib.uart_tx_en = v;
  endtask
  task automatic save_a(input logic [1:0] mask, input logic [3:0] data);
    @(negedge clk);
    ia.data_input = data;
    ia.save_n = ~mask;
    repeat (2) @(negedge clk);
    ia.save_n = '1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) if (mask[i]) ma[i] = int'(data);
  endtask
  task automatic save_b(input logic [3:0] mask, input logic [7:0] data);
    @(negedge clk);
    ib.data_input = data;
    ib.save_n = ~mask;
    repeat (2) @(negedge clk);
    ib.save_n = '1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) if (mask[i]) mb[i] = int'(data);
  endtask
  task automatic frame(input int sel, input int nbytes, input longint val, input bit inject);
    int c;
    int bad;
    int seen;
    logic tr [$];
    logic [7:0] got;
    logic [7:0] eb;
    @(negedge clk);
    set_en(sel, 1'b1);
    c = 0;
    while (!get_busy(sel) && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!get_busy(sel)) begin
      chk("frame_start", get_busy(sel), 1);
      set_en(sel, 1'b0);
      return;
    end
    chk("busy_txd_align", get_txd(sel), 0);
    c = 0;
    while (get_busy(sel) && c < nbytes * FB * CPB + 50) begin
      tr.push_back(get_txd(sel));
      if (c == 2) set_en(sel, 1'b0);
      if (inject) begin
        if (c == 8) begin
          ia.data_input = 4'd1;
          ia.save_n = 2'b10;
          ma[0] = 1;
        end
        if (c == 10) ia.save_n = 2'b11;
        if (c == 12) ia.uart_tx_en = 1'b1;
        if (c == 16) ia.uart_tx_en = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    chk("busy_len", c, nbytes * FB * CPB);
    bad = 0;
    for (int k = 0; k < tr.size(); k++) begin
      int b;
      b = k / (FB * CPB);
      eb = 8'((val >> (8 * b)) & 64'hFF);
      if (b < nbytes && tr[k] !== exp_bit(eb, (k / CPB) % FB)) bad++;
    end
    chk("frame_bits", bad, 0);
    for (int b = 0; b < nbytes; b++) begin
      got = '0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (b * FB + 1 + k) * CPB + CPB / 2;
        if (idx < tr.size()) got[k] = tr[idx];
      end
      chk("frame_byte", got, (val >> (8 * b)) & 64'hFF);
    end
    chk("idle_txd", get_txd(sel), 1);
    if (inject) begin
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (ia.uart_tx_busy) seen++;
      end
      chk("no_second_frame", seen, 0);
      chk("sum_after_inject", ia.sum_out, sum_a());
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int c;
    logic [1:0] m;
    logic [3:0] d;
    tv[0] = '{2'b10, 4'd9, 14};
    tv[1] = '{2'b11, 4'd15, 30};
    tv[2] = '{2'b11, 4'd7, 14};
    tv[3] = '{2'b01, 4'd0, 7};
    tv[4] = '{2'b10, 4'd15, 15};
    tv[5] = '{2'b01, 4'd5, 20};
    tv[6] = '{2'b11, 4'd2, 4};
    ma = '{0, 0};
    mb = '{0, 0, 0, 0};
    reset = 1'b1;
    ia.save_n = '1; ia.data_input = '0; ia.uart_tx_en = 1'b0;
    ib.save_n = '1; ib.data_input = '0; ib.uart_tx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd_a", ia.uart_txd, 1);
    chk("rst_busy_a", ia.uart_tx_busy, 0);
    chk("rst_sum_a", ia.sum_out, 0);
    chk("rst_sum_b", ib.sum_out, 0);
    chk("rst_txd_b", ib.uart_txd, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    ia.data_input = 4'd5;
    ia.save_n = 2'b10;
    repeat (3) @(posedge clk);
    #1 chk("sum_lat3", ia.sum_out, 0);
    @(posedge clk);
    #1 chk("sum_lat4", ia.sum_out, 5);
    @(negedge clk);
    ia.save_n = 2'b11;
    ma[0] = 5;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      save_a(tv[i].mask, tv[i].data);
      chk("tv_sum", ia.sum_out, tv[i].exp);
      chk("tv_model", ia.sum_out, sum_a());
      if (i < 2) frame(0, 1, longint'(tv[i].exp), 1'b0);
    end
    @(negedge clk);
    ia.data_input = 4'd3;
    ia.save_n = 2'b10;
    repeat (3) @(negedge clk);
    ia.data_input = 4'd12;
    repeat (4) @(negedge clk);
    ia.save_n = 2'b11;
    repeat (3) @(negedge clk);
    ma[0] = 3;
    chk("hold_once", ia.sum_out, sum_a());
    for (int i = 0; i < 20; i++) begin
      m = 2'($urandom_range(1, 3));
      d = 4'($urandom_range(0, 15));
      save_a(m, d);
      chk("rand_sum_a", ia.sum_out, sum_a());
    end
    frame(0, 1, longint'(sum_a()), 1'b0);
    frame(0, 1, longint'(sum_a()), 1'b1);
    save_b(4'b0001, 8'd255);
    save_b(4'b0010, 8'd255);
    save_b(4'b0100, 8'd255);
    save_b(4'b1000, 8'd3);
    chk("sum_b_768", ib.sum_out, 768);
    frame(1, 2, 768, 1'b0);
    for (int i = 0; i < 8; i++) begin
      save_b(4'($urandom_range(1, 15)), 8'($urandom_range(0, 255)));
      chk("rand_sum_b", ib.sum_out, sum_b());
    end
    frame(1, 2, longint'(sum_b()), 1'b0);
    @(negedge clk);
    ia.uart_tx_en = 1'b1;
    c = 0;
    while (!ia.uart_tx_busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rst_frame_started", ia.uart_tx_busy, 1);
    ia.uart_tx_en = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_txd", ia.uart_txd, 1);
    chk("midrst_busy", ia.uart_tx_busy, 0);
    chk("midrst_sum_a", ia.sum_out, 0);
    chk("midrst_sum_b", ib.sum_out, 0);
    ma = '{0, 0};
    mb = '{0, 0, 0, 0};
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    frame(0, 1, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
